dma_mem_ctrl: RTL and testbench

//  Memory-side controller behind the DMA sequencer. It shares one async SRAM port between the CPU and the

---
 rtl/dma_mem_ctrl_pkg.sv | 20 ++
 rtl/dma_mem_ctrl_arb.sv | 42 ++++
 rtl/dma_mem_ctrl.sv | 135 +++++++++++++
 tb/tb_dma_mem_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_mem_ctrl_pkg.sv
// Shared definitions for the DMA memory-side controller.
//   state_t : controller FSM states (IDLE, ACCESS, END)
//   owner_t : which requester owns the access in flight (CPU or DMA)
//   WCNT_W  : width of the wait-state and defer counters (covers 1..15)
package dma_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_END    = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_t;

  localparam int WCNT_W = 4;

endpackage

// File: rtl/dma_mem_ctrl_arb.sv
// mem_prio_arb: two-way fixed-priority arbiter between CPU and DMA with a
// saturating starvation counter. The CPU normally wins, but once it has been
// granted DMA_DEFER times in a row while the DMA request waited, the DMA wins.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   cpu_req, dma_req  request levels
//   grant_en          a grant may be issued this cycle
//   gnt_cpu, gnt_dma  one-hot grant (combinational)
module mem_prio_arb
  import dma_mem_ctrl_pkg::*;
#(
  parameter int DMA_DEFER = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic grant_en,
  output logic gnt_cpu,
  output logic gnt_dma
);

  logic [WCNT_W-1:0] defer_cnt;
  logic              dma_turn;

  assign dma_turn = dma_req && (defer_cnt == WCNT_W'(DMA_DEFER));
  assign gnt_cpu  = grant_en && cpu_req && !dma_turn;
  assign gnt_dma  = grant_en && dma_req && !gnt_cpu;

  // Count CPU grants that overtook a pending DMA request; any cycle without
  // a DMA request, or a DMA grant, restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      defer_cnt <= '0;
    end else if (gnt_dma || !dma_req) begin
      defer_cnt <= '0;
    end else if (gnt_cpu && (defer_cnt != WCNT_W'(DMA_DEFER))) begin
      defer_cnt <= defer_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dma_mem_ctrl.sv
// dma_mem_ctrl: shares one async SRAM port between the CPU and the DMA
// sequencer stream, driving the SRAM strobes with WAITS active cycles.
// Both sides use req/ack/end: ack pulses in the grant cycle, end pulses
// WAITS+1 cycles later, with read data valid in *_rd from the end cycle on.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   cpu_req/addr/rnw/wd -> cpu_ack/end/rd   CPU request side
//   dma_req/addr/rnw/wd -> dma_ack/end/rd   DMA sequencer side
//   mem_a, mem_do, mem_di               SRAM address, write data, read data
//   mem_doe, mem_we_n, mem_oe_n         SRAM data-drive enable and strobes
module dma_mem_ctrl
  import dma_mem_ctrl_pkg::*;
#(
  parameter int AW        = 21,
  parameter int DW        = 8,
  parameter int WAITS     = 2,
  parameter int DMA_DEFER = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_rnw,
  input  logic [DW-1:0] cpu_wd,
  output logic          cpu_ack,
  output logic          cpu_end,
  output logic [DW-1:0] cpu_rd,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic          dma_rnw,
  input  logic [DW-1:0] dma_wd,
  output logic          dma_ack,
  output logic          dma_end,
  output logic [DW-1:0] dma_rd,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_do,
  input  logic [DW-1:0] mem_di,
  output logic          mem_doe,
  output logic          mem_we_n,
  output logic          mem_oe_n
);

  state_t            state, state_nxt;
  owner_t            owner;
  logic              rnw;
  logic [WCNT_W-1:0] wait_cnt;
  logic              grant_en, gnt_cpu, gnt_dma, grant, wait_done;
  logic              sel_rnw;

  // Grants only in IDLE/END; gating with rst_n keeps acks low during reset.
  assign grant_en  = rst_n && ((state == ST_IDLE) || (state == ST_END));
  assign grant     = gnt_cpu || gnt_dma;
  assign wait_done = (wait_cnt == '0);
  assign sel_rnw   = gnt_dma ? dma_rnw : cpu_rnw;

  mem_prio_arb #(
    .DMA_DEFER (DMA_DEFER)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .grant_en (grant_en),
    .gnt_cpu  (gnt_cpu),
    .gnt_dma  (gnt_dma)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cpu_ack   = gnt_cpu;
    dma_ack   = gnt_dma;
    cpu_end   = 1'b0;
    dma_end   = 1'b0;
    case (state)
      ST_IDLE:   state_nxt = ST_IDLE;
      ST_ACCESS: if (wait_done) state_nxt = ST_END;
      ST_END: begin
        cpu_end   = (owner == OWNER_CPU);
        dma_end   = (owner == OWNER_DMA);
        state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
    if (grant) state_nxt = ST_ACCESS;
  end

  // Request latch, wait counter and registered strobes. Strobes are loaded
  // at the grant edge so they are active exactly during ACCESS; mem_a and
  // mem_do are left untouched after the access to provide address/data hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner    <= OWNER_CPU;
      rnw      <= 1'b1;
      wait_cnt <= '0;
      mem_a    <= '0;
      mem_do   <= '0;
      mem_doe  <= 1'b0;
      mem_we_n <= 1'b1;
      mem_oe_n <= 1'b1;
      cpu_rd   <= '0;
      dma_rd   <= '0;
    end else if (grant) begin
      owner    <= gnt_dma ? OWNER_DMA : OWNER_CPU;
      rnw      <= sel_rnw;
      mem_a    <= gnt_dma ? dma_addr : cpu_addr;
      mem_do   <= gnt_dma ? dma_wd : cpu_wd;
      wait_cnt <= WCNT_W'(WAITS - 1);
      mem_oe_n <= !sel_rnw;
      mem_we_n <= sel_rnw;
      mem_doe  <= !sel_rnw;
    end else if (state == ST_ACCESS) begin
      if (wait_done) begin
        mem_oe_n <= 1'b1;
        mem_we_n <= 1'b1;
        if (rnw) begin
          if (owner == OWNER_DMA) dma_rd <= mem_di;
          else                    cpu_rd <= mem_di;
        end
      end else begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end else if (state == ST_END) begin
      mem_doe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_mem_ctrl.sv
// Testbench for dma_mem_ctrl: directed scenarios on a WAITS=2 instance and a
// WAITS=1 instance, followed by randomized concurrent CPU/DMA traffic scored
// against a transaction-level model of arbitration, timing and memory.
module tb_dma_mem_ctrl;

  localparam int WAITS     = 2;
  localparam int DMA_DEFER = 4;
  localparam int NTX       = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_rnw, dma_req, dma_rnw;
  logic [20:0] cpu_addr, dma_addr, mem_a;
  logic [7:0]  cpu_wd, dma_wd, cpu_rd, dma_rd, mem_do, mem_di;
  logic        cpu_ack, cpu_end, dma_ack, dma_end, mem_doe, mem_we_n, mem_oe_n;

  logic        w1_dma_req, w1_dma_rnw, w1_cpu_ack, w1_cpu_end, w1_dma_ack, w1_dma_end;
  logic [20:0] w1_dma_addr, w1_mem_a;
  logic [7:0]  w1_cpu_rd, w1_dma_rd, w1_mem_do, w1_mem_di;
  logic        w1_mem_doe, w1_mem_we_n, w1_mem_oe_n;

  logic [7:0]  sram [256];
  logic        sram_ready = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dma_mem_ctrl #(.AW(21), .DW(8), .WAITS(WAITS), .DMA_DEFER(DMA_DEFER)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_wd(cpu_wd),
    .cpu_ack(cpu_ack), .cpu_end(cpu_end), .cpu_rd(cpu_rd),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_rnw(dma_rnw), .dma_wd(dma_wd),
    .dma_ack(dma_ack), .dma_end(dma_end), .dma_rd(dma_rd),
    .mem_a(mem_a), .mem_do(mem_do), .mem_di(mem_di),
    .mem_doe(mem_doe), .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n)
  );

  dma_mem_ctrl #(.AW(21), .DW(8), .WAITS(1), .DMA_DEFER(DMA_DEFER)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(1'b0), .cpu_addr(21'h0), .cpu_rnw(1'b1), .cpu_wd(8'h00),
    .cpu_ack(w1_cpu_ack), .cpu_end(w1_cpu_end), .cpu_rd(w1_cpu_rd),
    .dma_req(w1_dma_req), .dma_addr(w1_dma_addr), .dma_rnw(w1_dma_rnw), .dma_wd(8'h00),
    .dma_ack(w1_dma_ack), .dma_end(w1_dma_end), .dma_rd(w1_dma_rd),
    .mem_a(w1_mem_a), .mem_do(w1_mem_do), .mem_di(w1_mem_di),
    .mem_doe(w1_mem_doe), .mem_we_n(w1_mem_we_n), .mem_oe_n(w1_mem_oe_n)
  );

  function automatic logic [7:0] init_val(input int i);
    if (i == 'hCD) return 8'hA5;
    return 8'(i * 37 + 11);
  endfunction

  // SRAM model: 256 words aliased on the low address byte, written while the
  // write strobe and data drive are both active.
  assign mem_di    = sram[mem_a[7:0]];
  assign w1_mem_di = sram[w1_mem_a[7:0]];
  always @(posedge clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_val(i);
      sram_ready <= 1'b1;
    end else if (!mem_we_n && mem_doe) begin
      sram[mem_a[7:0]] <= mem_do;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Runs one isolated DMA transaction; cycle indices are relative to the
  // first cycle the request is visible.
  task automatic dma_txn(input logic [20:0] a, input logic rnw, input logic [7:0] wd,
                         output int t_ack, output int t_end, output int strb_first,
                         output int oe_cnt, output int we_cnt, output int doe_first,
                         output int doe_last, output logic [20:0] a_strb);
    t_ack = -1; t_end = -1; strb_first = -1; oe_cnt = 0; we_cnt = 0;
    doe_first = -1; doe_last = -1; a_strb = '0;
    @(posedge clk); #1;
    dma_req = 1'b1; dma_addr = a; dma_rnw = rnw; dma_wd = wd;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (dma_ack && t_ack < 0) t_ack = k;
      if (dma_end && t_end < 0) t_end = k;
      if ((!mem_oe_n || !mem_we_n) && strb_first < 0) begin
        strb_first = k; a_strb = mem_a;
      end
      if (!mem_oe_n) oe_cnt++;
      if (!mem_we_n) we_cnt++;
      if (mem_doe) begin
        if (doe_first < 0) doe_first = k;
        doe_last = k;
      end
      @(posedge clk); #1;
      if (t_ack >= 0) begin dma_req = 1'b0; dma_addr = 21'h1FFFF; dma_wd = 8'hEE; end
      if (t_end >= 0 && k > t_end) break;
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic        mon_en = 1'b0;
  logic        ref_ready = 1'b0;
  logic [7:0]  ref_mem [256];
  logic [7:0]  exp_cpu_rd, exp_dma_rd, cur_rd, cur_wd;
  logic [20:0] cur_addr;
  logic        busy, cur_dma, cur_rnw;
  logic        free, e_cend, e_dend, g_cpu, g_dma;
  int          cur_end, streak;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!ref_ready) begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        ref_mem[8'h10] = 8'h3C;
        exp_cpu_rd = init_val(5);
        exp_dma_rd = init_val(5);
        busy = 1'b0; streak = 0; ref_ready = 1'b1;
      end
      e_cend = 1'b0; e_dend = 1'b0;
      free = !busy;
      if (busy && cyc == cur_end) begin
        busy = 1'b0; free = 1'b1;
        e_cend = !cur_dma; e_dend = cur_dma;
        if (cur_rnw && cur_dma)  exp_dma_rd = cur_rd;
        if (cur_rnw && !cur_dma) exp_cpu_rd = cur_rd;
      end
      chk("rnd_cpu_end", 32'(cpu_end), 32'(e_cend));
      chk("rnd_dma_end", 32'(dma_end), 32'(e_dend));
      if (e_cend) chk("rnd_cpu_rd", 32'(cpu_rd), 32'(exp_cpu_rd));
      if (e_dend) chk("rnd_dma_rd", 32'(dma_rd), 32'(exp_dma_rd));
      if (busy) begin
        chk("rnd_mem_a", 32'(mem_a), 32'(cur_addr));
        chk("rnd_oe_n", 32'(mem_oe_n), 32'(!cur_rnw));
        chk("rnd_we_n", 32'(mem_we_n), 32'(cur_rnw));
        chk("rnd_doe", 32'(mem_doe), 32'(!cur_rnw));
        if (!cur_rnw) chk("rnd_mem_do", 32'(mem_do), 32'(cur_wd));
      end else begin
        chk("rnd_oe_idle", 32'(mem_oe_n), 32'(1));
        chk("rnd_we_idle", 32'(mem_we_n), 32'(1));
      end
      // CPU first, unless it has already overtaken a waiting DMA DMA_DEFER times.
      g_dma = free && dma_req && !(cpu_req && streak < DMA_DEFER);
      g_cpu = free && cpu_req && !g_dma;
      chk("rnd_cpu_ack", 32'(cpu_ack), 32'(g_cpu));
      chk("rnd_dma_ack", 32'(dma_ack), 32'(g_dma));
      if (!dma_req || g_dma) streak = 0;
      else if (g_cpu)        streak++;
      if (g_cpu || g_dma) begin
        busy     = 1'b1;
        cur_dma  = g_dma;
        cur_rnw  = g_dma ? dma_rnw : cpu_rnw;
        cur_addr = g_dma ? dma_addr : cpu_addr;
        cur_wd   = g_dma ? dma_wd : cpu_wd;
        cur_end  = cyc + WAITS + 1;
        if (cur_rnw) cur_rd = ref_mem[cur_addr[7:0]];
        else         ref_mem[cur_addr[7:0]] = cur_wd;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t_ack, t_end, s_first, oe_cnt, we_cnt, d_first, d_last, n, ta, te, oe_bad;
    logic [20:0] a_strb;
    logic        ends;
    logic        order [10];
    int          ack_t [3];
    int          end_t [3];
    logic [7:0]  rd_v  [3];
    logic [20:0] b2b_a [3];
    int          na, ne;

    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_addr = 21'h0; cpu_rnw = 1'b1; cpu_wd = 8'h0;
    dma_req = 1'b1; dma_addr = 21'h0; dma_rnw = 1'b1; dma_wd = 8'h0;
    w1_dma_req = 1'b0; w1_dma_addr = 21'h0; w1_dma_rnw = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_we_n", 32'(mem_we_n), 32'(1));
    chk("rst_oe_n", 32'(mem_oe_n), 32'(1));
    chk("rst_doe", 32'(mem_doe), 32'(0));
    chk("rst_mem_a", 32'(mem_a), 32'(0));
    chk("rst_mem_do", 32'(mem_do), 32'(0));
    chk("rst_rds", 32'({cpu_rd, dma_rd}), 32'(0));
    chk("rst_acks", 32'({cpu_ack, dma_ack, cpu_end, dma_end}), 32'(0));
    cpu_req = 1'b0; dma_req = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single DMA read
    dma_txn(21'h1ABCD, 1'b1, 8'h00, t_ack, t_end, s_first, oe_cnt, we_cnt, d_first, d_last, a_strb);
    chk("t1_ack", 32'(t_ack), 32'(0));
    chk("t1_strobe_first", 32'(s_first), 32'(1));
    chk("t1_oe_cycles", 32'(oe_cnt), 32'(2));
    chk("t1_we_cycles", 32'(we_cnt), 32'(0));
    chk("t1_end", 32'(t_end), 32'(3));
    chk("t1_addr", 32'(a_strb), 32'(21'h1ABCD));
    chk("t1_rd", 32'(dma_rd), 32'(8'hA5));

    // single DMA write
    dma_txn(21'h00010, 1'b0, 8'h3C, t_ack, t_end, s_first, oe_cnt, we_cnt, d_first, d_last, a_strb);
    chk("t2_we_cycles", 32'(we_cnt), 32'(2));
    chk("t2_oe_cycles", 32'(oe_cnt), 32'(0));
    chk("t2_doe_first", 32'(d_first), 32'(1));
    chk("t2_doe_last", 32'(d_last), 32'(3));
    chk("t2_end", 32'(t_end), 32'(3));
    chk("t2_mem", 32'(sram[8'h10]), 32'(8'h3C));
    chk("t2_rd_kept", 32'(dma_rd), 32'(8'hA5));

    // reset in the middle of a write
    @(posedge clk); #1;
    dma_req = 1'b1; dma_addr = 21'h00030; dma_rnw = 1'b0; dma_wd = 8'h77;
    @(negedge clk);
    chk("t5_ack", 32'(dma_ack), 32'(1));
    @(posedge clk); #1;
    dma_req = 1'b0;
    @(negedge clk);
    chk("t5_we_active", 32'(mem_we_n), 32'(0));
    rst_n = 1'b0;
    #1;
    chk("t5_we_abort", 32'(mem_we_n), 32'(1));
    chk("t5_doe_abort", 32'(mem_doe), 32'(0));
    ends = 1'b0;
    repeat (3) begin @(negedge clk); ends = ends | dma_end; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); ends = ends | dma_end; end
    chk("t5_no_end", 32'(ends), 32'(0));
    chk("t5_rd_cleared", 32'(dma_rd), 32'(0));
    dma_txn(21'h1ABCD, 1'b1, 8'h00, t_ack, t_end, s_first, oe_cnt, we_cnt, d_first, d_last, a_strb);
    chk("t5_after_end", 32'(t_end), 32'(3));
    chk("t5_after_rd", 32'(dma_rd), 32'(8'hA5));

    // back-to-back DMA reads
    b2b_a[0] = 21'h20; b2b_a[1] = 21'h21; b2b_a[2] = 21'h22;
    na = 0; ne = 0;
    @(posedge clk); #1;
    dma_req = 1'b1; dma_rnw = 1'b1; dma_addr = b2b_a[0];
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (dma_end && ne < 3) begin end_t[ne] = k; rd_v[ne] = dma_rd; ne++; end
      if (dma_ack && na < 3) begin
        ack_t[na] = k; na++;
        @(posedge clk); #1;
        if (na < 3) dma_addr = b2b_a[na];
        else        dma_req = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("t4_acks", 32'(na), 32'(3));
    chk("t4_ends", 32'(ne), 32'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < na && i < ne) begin
        chk("t4_ack_time", 32'(ack_t[i]), 32'(3 * i));
        chk("t4_end_time", 32'(end_t[i]), 32'(3 * i + 3));
        chk("t4_rd", 32'(rd_v[i]), 32'(init_val(32 + i)));
      end
    end

    // contention: both held high
    n = 0;
    @(posedge clk); #1;
    cpu_req = 1'b1; dma_req = 1'b1; cpu_rnw = 1'b1; dma_rnw = 1'b1;
    cpu_addr = 21'h05; dma_addr = 21'h05;
    for (int k = 0; k < 100 && n < 10; k++) begin
      @(negedge clk);
      if (cpu_ack && dma_ack) chk("t3_onehot", 32'(1), 32'(0));
      if (cpu_ack || dma_ack) begin order[n] = dma_ack; n++; end
      @(posedge clk); #1;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    chk("t3_grants", 32'(n), 32'(10));
    for (int i = 0; i < 10; i++)
      if (i < n) chk("t3_order", 32'(order[i]), 32'((i % 5) == 4));
    repeat (6) @(negedge clk);

    // WAITS=1 read on the second instance
    ta = -1; te = -1; oe_cnt = 0; oe_bad = 0;
    @(posedge clk); #1;
    w1_dma_req = 1'b1; w1_dma_addr = 21'h1ABCD; w1_dma_rnw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (w1_dma_ack && ta < 0) ta = k;
      if (w1_dma_end && te < 0) te = k;
      if (!w1_mem_oe_n) begin oe_cnt++; if (k != 1) oe_bad++; end
      if (!w1_mem_we_n) oe_bad++;
      @(posedge clk); #1;
      if (ta >= 0) w1_dma_req = 1'b0;
    end
    chk("t6_ack", 32'(ta), 32'(0));
    chk("t6_end", 32'(te), 32'(2));
    chk("t6_oe_cycles", 32'(oe_cnt), 32'(1));
    chk("t6_strobe_outside", 32'(oe_bad), 32'(0));
    chk("t6_rd", 32'(w1_dma_rd), 32'(8'hA5));

    // randomized concurrent traffic
    @(posedge clk); #1;
    mon_en = 1'b1;
    fork
      begin : cpu_drv
        logic got;
        for (int i = 0; i < NTX; i++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          #1;
          cpu_req = 1'b1; cpu_addr = 21'($urandom_range(0, 31));
          cpu_rnw = 1'($urandom_range(0, 1)); cpu_wd = 8'($urandom);
          got = 1'b0;
          for (int t = 0; t < 100 && !got; t++) begin @(negedge clk); got = cpu_ack; end
          chk("rnd_cpu_ack_wait", 32'(got), 32'(1));
          @(posedge clk); #1;
          cpu_req = 1'b0; cpu_addr = 21'($urandom); cpu_wd = 8'($urandom);
        end
      end
      begin : dma_drv
        logic got;
        for (int i = 0; i < NTX; i++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          #1;
          dma_req = 1'b1; dma_addr = 21'($urandom_range(0, 31));
          dma_rnw = 1'($urandom_range(0, 1)); dma_wd = 8'($urandom);
          got = 1'b0;
          for (int t = 0; t < 100 && !got; t++) begin @(negedge clk); got = dma_ack; end
          chk("rnd_dma_ack_wait", 32'(got), 32'(1));
          @(posedge clk); #1;
          dma_req = 1'b0; dma_addr = 21'($urandom); dma_wd = 8'($urandom);
        end
      end
    join
    repeat (8) @(negedge clk);
    chk("rnd_drained", 32'(busy), 32'(0));
    @(posedge clk); #1;
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
